dcache_ctrl: RTL

//  MEM-stage L1 data cache. Sits directly downstream of the EX/MEM pipeline register.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/dcache_sram.sv | 63 ++++++
 rtl/dcache_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the MEM-stage L1 data cache.
//   - Default geometry (lines, block width, address width) and the word width.
//   - Controller FSM state encoding.
//   - Helper mapping a word-within-line number to its bit position in the line.
package cache_pkg;

    localparam int unsigned CACHE_LINES   = 32;
    localparam int unsigned CACHE_BLOCK_W = 256;
    localparam int unsigned CACHE_ADDR_W  = 32;
    localparam int unsigned WORD_W        = 32;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWriteback = 2'd1,
        StAllocate  = 2'd2
    } state_e;

    // Bit offset of 32-bit word 'w' inside a cache line.
    function automatic int unsigned word_lsb(input int unsigned w);
        return w * WORD_W;
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Storage for the direct-mapped data cache.
//   clk, rst_n        : clock, async active-low reset (clears valid/dirty only)
//   index             : line selected for read and for both write ports
//   rd_tag/rd_valid/rd_dirty/rd_line : combinational read of the selected line
//   ww_en/ww_word/ww_data : store-hit word write; marks the line dirty
//   fill_en/fill_tag/fill_line : whole-line refill; line becomes valid and clean
// Tag and data arrays are deliberately left unreset.
module dcache_sram
    import cache_pkg::*;
#(
    parameter int unsigned LINES   = CACHE_LINES,
    parameter int unsigned BLOCK_W = CACHE_BLOCK_W,
    parameter int unsigned TAG_W   = 22,
    localparam int unsigned IDX_W  = $clog2(LINES),
    localparam int unsigned WSEL_W = $clog2(BLOCK_W / WORD_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IDX_W-1:0]   index,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    output logic               rd_dirty,
    output logic [BLOCK_W-1:0] rd_line,
    input  logic               ww_en,
    input  logic [WSEL_W-1:0]  ww_word,
    input  logic [WORD_W-1:0]  ww_data,
    input  logic               fill_en,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic [BLOCK_W-1:0] fill_line
);

    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [BLOCK_W-1:0] data_q [LINES];
    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[index]  <= fill_tag;
            data_q[index] <= fill_line;
        end else if (ww_en) begin
            data_q[index][word_lsb(32'(ww_word)) +: WORD_W] <= ww_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (ww_en) begin
            dirty_q[index] <= 1'b1;
        end
    end

    assign rd_tag   = tag_q[index];
    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_line  = data_q[index];

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage L1 data cache: direct-mapped, write-back, write-allocate.
//   Clock_i, Reset_n_i      : clock, async active-low reset
//   MemRead_i, MemWrite_i   : load / store request from EX/MEM
//   Addr_i, WriteData_i     : byte address and store data
//   ReadData_o              : load data, valid when MemRead_i & ~stall_o
//   stall_o                 : freezes the pipeline while a miss is serviced
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o : block request to slow memory
//   mem_ack_i/mem_rdata_i   : one-cycle completion pulse and fetched line
module dcache_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned LINES   = CACHE_LINES,
    parameter int unsigned BLOCK_W = CACHE_BLOCK_W,
    parameter int unsigned ADDR_W  = CACHE_ADDR_W
) (
    input  logic               Clock_i,
    input  logic               Reset_n_i,
    input  logic               MemRead_i,
    input  logic               MemWrite_i,
    input  logic [ADDR_W-1:0]  Addr_i,
    input  logic [WORD_W-1:0]  WriteData_i,
    output logic [WORD_W-1:0]  ReadData_o,
    output logic               stall_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [ADDR_W-1:0]  mem_addr_o,
    output logic [BLOCK_W-1:0] mem_wdata_o,
    input  logic               mem_ack_i,
    input  logic [BLOCK_W-1:0] mem_rdata_i
);

    localparam int unsigned OFF_W  = $clog2(BLOCK_W / 8);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int unsigned WSEL_W = OFF_W - 2;

    logic [WSEL_W-1:0]  word;
    logic [IDX_W-1:0]   index;
    logic [TAG_W-1:0]   tag;

    logic [TAG_W-1:0]   rd_tag;
    logic               rd_valid;
    logic               rd_dirty;
    logic [BLOCK_W-1:0] rd_line;

    logic               access;
    logic               hit;
    logic               ww_en;
    logic               fill_en;
    logic               stall;
    logic [WORD_W-1:0]  rdata;

    state_e state_q, state_d;

    assign word   = Addr_i[OFF_W-1:2];
    assign index  = Addr_i[OFF_W+IDX_W-1:OFF_W];
    assign tag    = Addr_i[ADDR_W-1:OFF_W+IDX_W];
    assign access = MemRead_i | MemWrite_i;
    assign hit    = rd_valid && (rd_tag == tag);

    dcache_sram #(
        .LINES   (LINES),
        .BLOCK_W (BLOCK_W),
        .TAG_W   (TAG_W)
    ) u_sram (
        .clk       (Clock_i),
        .rst_n     (Reset_n_i),
        .index     (index),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_line   (rd_line),
        .ww_en     (ww_en),
        .ww_word   (word),
        .ww_data   (WriteData_i),
        .fill_en   (fill_en),
        .fill_tag  (tag),
        .fill_line (mem_rdata_i)
    );

    always_ff @(posedge Clock_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        rdata       = '0;
        ww_en       = 1'b0;
        fill_en     = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        unique case (state_q)
            StIdle: begin
                if (access) begin
                    if (hit) begin
                        // rd_line is the pre-store line, so a read+write shows the old word.
                        if (MemRead_i) begin
                            rdata = rd_line[word_lsb(32'(word)) +: WORD_W];
                        end
                        ww_en = MemWrite_i;
                    end else begin
                        stall   = 1'b1;
                        state_d = (rd_valid && rd_dirty) ? StWriteback : StAllocate;
                    end
                end
            end
            StWriteback: begin
                stall       = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {rd_tag, index, OFF_W'(0)};
                mem_wdata_o = rd_line;
                if (mem_ack_i) begin
                    state_d = StAllocate;
                end
            end
            StAllocate: begin
                stall      = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {tag, index, OFF_W'(0)};
                if (mem_ack_i) begin
                    fill_en = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // While reset is held the FSM sits in idle, but a held-over miss must not
    // raise stall or leak data onto the pipeline.
    assign stall_o    = stall & Reset_n_i;
    assign ReadData_o = Reset_n_i ? rdata : '0;

endmodule
